// File: rtl/weight_row_reader_if.sv
// Output beat channel of weight_row_reader: valid/ready handshake carrying one
// row or column of four weights per beat.
interface weight_row_reader_if #(
   parameter int unsigned WIDTH = 5
) ();
   logic                   out_valid;
   logic                   out_ready;
   logic [4*WIDTH-1:0]     out_data;
   logic [1:0]             out_idx;
   logic                   out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_idx,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_idx,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/weight_row_reader.sv
// Snapshots a 4x4 weight matrix on start and streams it out as four beats,
// row-major or column-major, over a valid/ready channel.
module weight_row_reader #(
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] W0,
   input  logic [WIDTH-1:0] W1,
   input  logic [WIDTH-1:0] W2,
   input  logic [WIDTH-1:0] W3,
   input  logic [WIDTH-1:0] W4,
   input  logic [WIDTH-1:0] W5,
   input  logic [WIDTH-1:0] W6,
   input  logic [WIDTH-1:0] W7,
   input  logic [WIDTH-1:0] W8,
   input  logic [WIDTH-1:0] W9,
   input  logic [WIDTH-1:0] W10,
   input  logic [WIDTH-1:0] W11,
   input  logic [WIDTH-1:0] W12,
   input  logic [WIDTH-1:0] W13,
   input  logic [WIDTH-1:0] W14,
   input  logic [WIDTH-1:0] W15,
   input  logic             start,
   input  logic             col_mode,
   weight_row_reader_if.master bus,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]         state;
   logic [1:0]         idx;
   logic               mode;
   logic [WIDTH-1:0]   snap [16];
   logic [WIDTH-1:0]   w_in [16];
   logic [4*WIDTH-1:0] lanes;

   assign w_in[0]  = W0;
   assign w_in[1]  = W1;
   assign w_in[2]  = W2;
   assign w_in[3]  = W3;
   assign w_in[4]  = W4;
   assign w_in[5]  = W5;
   assign w_in[6]  = W6;
   assign w_in[7]  = W7;
   assign w_in[8]  = W8;
   assign w_in[9]  = W9;
   assign w_in[10] = W10;
   assign w_in[11] = W11;
   assign w_in[12] = W12;
   assign w_in[13] = W13;
   assign w_in[14] = W14;
   assign w_in[15] = W15;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         mode  <= 1'b0;
         for (int unsigned i = 0; i < 16; i++) snap[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  for (int unsigned i = 0; i < 16; i++) snap[i] <= w_in[i];
                  mode  <= col_mode;
                  idx   <= '0;
                  state <= SEND;
               end
            end
            SEND: begin
               if (bus.out_ready) begin
                  // idx wraps to 0 on the last beat, but the state leaves SEND
                  idx <= idx + 2'd1;
                  if (idx == 2'd3) state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Row-major selects snapshot element 4*idx+j, column-major 4*j+idx.
   always_comb begin
      lanes = '0;
      for (int unsigned j = 0; j < 4; j++) begin
         lanes[j*WIDTH +: WIDTH] = mode ? snap[{2'(j), idx}] : snap[{idx, 2'(j)}];
      end
   end

   always_comb begin
      bus.out_valid = (state == SEND);
      bus.out_data  = (state == SEND) ? lanes : '0;
      bus.out_idx   = (state == SEND) ? idx : '0;
      bus.out_last  = (state == SEND) && (idx == 2'd3);
      busy          = (state != IDLE);
      done          = (state == DONE);
   end

endmodule
